// File: rtl/mem_pkg.sv
// Shared types and lane geometry for the memory-access stage.
package mem_pkg;

  localparam int unsigned LANES      = 4;
  localparam int unsigned VLANE_W    = 32;
  localparam int unsigned SDATA_W    = 36;
  localparam int unsigned LANE_IDX_W = $clog2(LANES);

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_LOAD  = 2'b01,
    MEM_STORE = 2'b10
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } mem_state_t;

endpackage

// File: rtl/lane_pack.sv
// Combinational lane packing: builds store line/mask and extracts load results from a cache line.
module lane_pack
  import mem_pkg::*;
(
  input  logic [LANE_IDX_W-1:0]    lane_i,
  input  logic                     vec_i,
  input  logic [SDATA_W-1:0]       sdata_i,
  input  logic [LANES*VLANE_W-1:0] vdata_i,
  input  logic [LANES*SDATA_W-1:0] rdata_i,
  output logic [LANES*SDATA_W-1:0] wdata_o,
  output logic [LANES-1:0]         wmask_o,
  output logic [SDATA_W-1:0]       rlane_o,
  output logic [LANES*VLANE_W-1:0] rvec_o
);

  always_comb begin
    wdata_o = '0;
    wmask_o = '0;
    rvec_o  = '0;
    for (int i = 0; i < LANES; i++) begin
      if (vec_i) begin
        // Vector lanes are narrower than cache lanes; upper bits are zero-filled.
        wdata_o[i*SDATA_W +: SDATA_W] = SDATA_W'(vdata_i[i*VLANE_W +: VLANE_W]);
        wmask_o[i]                    = 1'b1;
      end else begin
        wdata_o[i*SDATA_W +: SDATA_W] = sdata_i;
        wmask_o[i]                    = (lane_i == LANE_IDX_W'(i));
      end
      rvec_o[i*VLANE_W +: VLANE_W] = rdata_i[i*SDATA_W +: VLANE_W];
    end
  end

  assign rlane_o = rdata_i[int'(lane_i)*SDATA_W +: SDATA_W];

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: registers execute results, runs one cache access at a time, feeds writeback.
// Optional MEM_ALIGN_CHECK_EN: drop misaligned vector accesses and pulse err_o.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 36
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     ex_valid_i,
  input  logic [1:0]               ex_mem_op_i,
  input  logic                     ex_vector_i,
  input  logic [ADDR_W-1:0]        ex_addr_i,
  input  logic [SDATA_W-1:0]       ex_sdata_i,
  input  logic [LANES*VLANE_W-1:0] ex_vdata_i,
  input  logic [SDATA_W-1:0]       ex_alu_data_i,
  input  logic [4:0]               ex_wr_reg_i,
  output logic                     stall_o,
  output logic                     dc_req_valid_o,
  input  logic                     dc_req_ready_i,
  output logic                     dc_req_we_o,
  output logic [ADDR_W-1:0]        dc_req_addr_o,
  output logic [LANES*SDATA_W-1:0] dc_req_wdata_o,
  output logic [LANES-1:0]         dc_req_wmask_o,
  input  logic                     dc_resp_valid_i,
  input  logic [LANES*SDATA_W-1:0] dc_resp_rdata_i,
  output logic                     wb_valid_o,
  output logic [SDATA_W-1:0]       wb_sdata_o,
  output logic [LANES*VLANE_W-1:0] wb_vdata_o,
  output logic                     wb_is_vector_o,
  output logic                     wb_is_load_o,
  output logic [4:0]               wb_wr_reg_o,
  output logic                     err_o
);

  mem_state_t state_q, state_d;

  logic                     we_q, we_d, vec_q, vec_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [SDATA_W-1:0]       sdata_q, sdata_d;
  logic [LANES*VLANE_W-1:0] vdata_q, vdata_d;
  logic [4:0]               wr_reg_q, wr_reg_d;

  logic                     wb_valid_q, wb_valid_d, wb_is_vector_q, wb_is_vector_d;
  logic                     wb_is_load_q, wb_is_load_d;
  logic [SDATA_W-1:0]       wb_sdata_q, wb_sdata_d;
  logic [LANES*VLANE_W-1:0] wb_vdata_q, wb_vdata_d;
  logic [4:0]               wb_wr_reg_q, wb_wr_reg_d;

  logic                     is_mem, misaligned, accept_mem, in_req;
  logic [LANES*SDATA_W-1:0] pk_wdata;
  logic [LANES-1:0]         pk_wmask;
  logic [SDATA_W-1:0]       pk_rlane;
  logic [LANES*VLANE_W-1:0] pk_rvec;

  assign is_mem = (ex_mem_op_i == MEM_LOAD) || (ex_mem_op_i == MEM_STORE);

`ifdef MEM_ALIGN_CHECK_EN
  logic err_q, err_d;
  assign misaligned = ex_vector_i && (ex_addr_i[1:0] != 2'b00);
  assign err_d      = (state_q == IDLE) && ex_valid_i && is_mem && misaligned;
  assign err_o      = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= err_d;
  end
`else
  assign misaligned = 1'b0;
  assign err_o      = 1'b0;
`endif

  assign accept_mem = (state_q == IDLE) && ex_valid_i && is_mem && !misaligned;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept_mem) state_d = REQ;
      REQ:     if (dc_req_ready_i) state_d = RESP;
      RESP:    if (dc_resp_valid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_o = (state_q != IDLE);
    in_req  = (state_q == REQ);
  end

  always_comb begin
    we_d     = we_q;
    vec_d    = vec_q;
    addr_d   = addr_q;
    sdata_d  = sdata_q;
    vdata_d  = vdata_q;
    wr_reg_d = wr_reg_q;
    if (accept_mem) begin
      we_d     = (ex_mem_op_i == MEM_STORE);
      vec_d    = ex_vector_i;
      addr_d   = ex_addr_i;
      sdata_d  = ex_sdata_i;
      vdata_d  = ex_vdata_i;
      wr_reg_d = ex_wr_reg_i;
    end
  end

  lane_pack u_lane_pack (
    .lane_i  (addr_q[LANE_IDX_W-1:0]),
    .vec_i   (vec_q),
    .sdata_i (sdata_q),
    .vdata_i (vdata_q),
    .rdata_i (dc_resp_rdata_i),
    .wdata_o (pk_wdata),
    .wmask_o (pk_wmask),
    .rlane_o (pk_rlane),
    .rvec_o  (pk_rvec)
  );

  // Request fields come only from captured registers so they hold until accepted.
  assign dc_req_valid_o = in_req;
  assign dc_req_we_o    = in_req & we_q;
  assign dc_req_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
  assign dc_req_wdata_o = pk_wdata;
  assign dc_req_wmask_o = in_req ? pk_wmask : '0;

  always_comb begin
    wb_valid_d     = 1'b0;
    wb_sdata_d     = wb_sdata_q;
    wb_vdata_d     = wb_vdata_q;
    wb_is_vector_d = wb_is_vector_q;
    wb_is_load_d   = wb_is_load_q;
    wb_wr_reg_d    = wb_wr_reg_q;
    if ((state_q == IDLE) && ex_valid_i && !is_mem) begin
      wb_valid_d     = 1'b1;
      wb_sdata_d     = ex_alu_data_i;
      wb_vdata_d     = '0;
      wb_is_vector_d = 1'b0;
      wb_is_load_d   = 1'b0;
      wb_wr_reg_d    = ex_wr_reg_i;
    end else if ((state_q == RESP) && dc_resp_valid_i) begin
      wb_valid_d     = 1'b1;
      wb_is_load_d   = !we_q;
      wb_is_vector_d = vec_q && !we_q;
      wb_sdata_d     = (we_q || vec_q) ? '0 : pk_rlane;
      wb_vdata_d     = (!we_q && vec_q) ? pk_rvec : '0;
      wb_wr_reg_d    = wr_reg_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q           <= 1'b0;
      vec_q          <= 1'b0;
      addr_q         <= '0;
      sdata_q        <= '0;
      vdata_q        <= '0;
      wr_reg_q       <= '0;
      wb_valid_q     <= 1'b0;
      wb_sdata_q     <= '0;
      wb_vdata_q     <= '0;
      wb_is_vector_q <= 1'b0;
      wb_is_load_q   <= 1'b0;
      wb_wr_reg_q    <= '0;
    end else begin
      we_q           <= we_d;
      vec_q          <= vec_d;
      addr_q         <= addr_d;
      sdata_q        <= sdata_d;
      vdata_q        <= vdata_d;
      wr_reg_q       <= wr_reg_d;
      wb_valid_q     <= wb_valid_d;
      wb_sdata_q     <= wb_sdata_d;
      wb_vdata_q     <= wb_vdata_d;
      wb_is_vector_q <= wb_is_vector_d;
      wb_is_load_q   <= wb_is_load_d;
      wb_wr_reg_q    <= wb_wr_reg_d;
    end
  end

  assign wb_valid_o     = wb_valid_q;
  assign wb_sdata_o     = wb_sdata_q;
  assign wb_vdata_o     = wb_vdata_q;
  assign wb_is_vector_o = wb_is_vector_q;
  assign wb_is_load_o   = wb_is_load_q;
  assign wb_wr_reg_o    = wb_wr_reg_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vector table, hand-written reset/back-to-back
// sequences and randomized ops against a transaction-level model.
module tb_mem_access_stage;
  import mem_pkg::*;

  localparam int unsigned AW = 36;
  localparam int unsigned LW = LANES * SDATA_W;
  localparam int unsigned VW = LANES * VLANE_W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ex_valid, ex_vector;
  logic [1:0]    ex_mem_op;
  logic [AW-1:0] ex_addr;
  logic [SDATA_W-1:0] ex_sdata, ex_alu_data;
  logic [VW-1:0] ex_vdata;
  logic [4:0]    ex_wr_reg;
  logic          stall, dc_req_valid, dc_req_ready, dc_req_we, dc_resp_valid;
  logic [AW-1:0] dc_req_addr;
  logic [LW-1:0] dc_req_wdata, dc_resp_rdata;
  logic [LANES-1:0] dc_req_wmask;
  logic          wb_valid, wb_is_vector, wb_is_load, err;
  logic [SDATA_W-1:0] wb_sdata;
  logic [VW-1:0] wb_vdata;
  logic [4:0]    wb_wr_reg;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_W(AW)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .ex_valid_i      (ex_valid),
    .ex_mem_op_i     (ex_mem_op),
    .ex_vector_i     (ex_vector),
    .ex_addr_i       (ex_addr),
    .ex_sdata_i      (ex_sdata),
    .ex_vdata_i      (ex_vdata),
    .ex_alu_data_i   (ex_alu_data),
    .ex_wr_reg_i     (ex_wr_reg),
    .stall_o         (stall),
    .dc_req_valid_o  (dc_req_valid),
    .dc_req_ready_i  (dc_req_ready),
    .dc_req_we_o     (dc_req_we),
    .dc_req_addr_o   (dc_req_addr),
    .dc_req_wdata_o  (dc_req_wdata),
    .dc_req_wmask_o  (dc_req_wmask),
    .dc_resp_valid_i (dc_resp_valid),
    .dc_resp_rdata_i (dc_resp_rdata),
    .wb_valid_o      (wb_valid),
    .wb_sdata_o      (wb_sdata),
    .wb_vdata_o      (wb_vdata),
    .wb_is_vector_o  (wb_is_vector),
    .wb_is_load_o    (wb_is_load),
    .wb_wr_reg_o     (wb_wr_reg),
    .err_o           (err)
  );

  typedef struct {
    logic [1:0]         op;
    logic               vec;
    logic [AW-1:0]      addr;
    logic [SDATA_W-1:0] sdata;
    logic [VW-1:0]      vdata;
    logic [SDATA_W-1:0] alu;
    logic [4:0]         wr;
    int                 rdy_dly;
    int                 resp_dly;
    logic [LW-1:0]      rdata;
    logic               junk_resp;
    logic [AW-1:0]      e_addr;
    logic               e_we;
    logic [LW-1:0]      e_wdata;
    logic [LANES-1:0]   e_wmask;
    logic [SDATA_W-1:0] e_sdata;
    logic [VW-1:0]      e_vdata;
    logic               e_vec;
    logic               e_load;
  } vec_t;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic vec, input logic [AW-1:0] addr,
                              input logic [SDATA_W-1:0] sdata, input logic [VW-1:0] vdata,
                              input logic [SDATA_W-1:0] alu, input logic [4:0] wr,
                              input int rdy, input int resp, input logic [LW-1:0] rdata);
    vec_t v;
    v.op = op; v.vec = vec; v.addr = addr; v.sdata = sdata; v.vdata = vdata; v.alu = alu;
    v.wr = wr; v.rdy_dly = rdy; v.resp_dly = resp; v.rdata = rdata; v.junk_resp = 1'b0;
    v.e_addr = '0; v.e_we = 1'b0; v.e_wdata = '0; v.e_wmask = '0; v.e_sdata = '0;
    v.e_vdata = '0; v.e_vec = 1'b0; v.e_load = 1'b0;
    return v;
  endfunction

  // Reference model: what the cache and writeback should see for one operation.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int lane;
    r = v;
    lane = int'(v.addr[1:0]);
    r.e_addr = v.addr & ~AW'(3);
    r.e_we   = (v.op == 2'b10);
    r.e_load = (v.op == 2'b01);
    r.e_vec  = v.vec && r.e_load;
    r.e_wmask = v.vec ? 4'b1111 : (4'b0001 << lane);
    for (int i = 0; i < LANES; i++) begin
      r.e_wdata[i*SDATA_W +: SDATA_W] = v.vec ? SDATA_W'(v.vdata[i*VLANE_W +: VLANE_W]) : v.sdata;
      r.e_vdata[i*VLANE_W +: VLANE_W] = v.rdata[i*SDATA_W +: VLANE_W];
    end
    if (v.op == 2'b01 || v.op == 2'b10) r.e_sdata = SDATA_W'(v.rdata >> (SDATA_W * lane));
    else                                r.e_sdata = v.alu;
    return r;
  endfunction

  task automatic apply(input vec_t v, input bit idle_after);
    bit mem;
    mem = (v.op == 2'b01) || (v.op == 2'b10);
    ex_valid = 1'b1; ex_mem_op = v.op; ex_vector = v.vec; ex_addr = v.addr;
    ex_sdata = v.sdata; ex_vdata = v.vdata; ex_alu_data = v.alu; ex_wr_reg = v.wr;
    tick();
    if (!mem) begin
      chk("pt_wb_valid", LW'(wb_valid), LW'(1'b1));
      chk("pt_wb_sdata", LW'(wb_sdata), LW'(v.e_sdata));
      chk("pt_wb_wr_reg", LW'(wb_wr_reg), LW'(v.wr));
      chk("pt_wb_is_load", LW'(wb_is_load), LW'(1'b0));
      chk("pt_stall", LW'(stall), LW'(1'b0));
      chk("pt_req_valid", LW'(dc_req_valid), LW'(1'b0));
      ex_valid = 1'b0;
    end else begin
      // Upstream moves on; scramble inputs so only captured values can reach the cache.
      ex_valid = 1'b0; ex_mem_op = 2'b00; ex_vector = ~v.vec; ex_addr = ~v.addr;
      ex_sdata = ~v.sdata; ex_vdata = ~v.vdata;
      chk("cap_wb_valid", LW'(wb_valid), LW'(1'b0));
      for (int c = 0; c <= v.rdy_dly; c++) begin
        chk("req_valid", LW'(dc_req_valid), LW'(1'b1));
        chk("req_stall", LW'(stall), LW'(1'b1));
        chk("req_addr", LW'(dc_req_addr), LW'(v.e_addr));
        chk("req_we", LW'(dc_req_we), LW'(v.e_we));
        if (v.e_we) begin
          chk("req_wdata", dc_req_wdata, v.e_wdata);
          chk("req_wmask", LW'(dc_req_wmask), LW'(v.e_wmask));
        end
        if (c == v.rdy_dly) begin
          dc_req_ready = 1'b1;
          dc_resp_valid = v.junk_resp;
          dc_resp_rdata = ~v.rdata;
        end
        tick();
      end
      dc_req_ready = 1'b0;
      dc_resp_valid = 1'b0;
      for (int c = 0; c <= v.resp_dly; c++) begin
        chk("resp_req_valid", LW'(dc_req_valid), LW'(1'b0));
        chk("resp_stall", LW'(stall), LW'(1'b1));
        chk("resp_wb_valid", LW'(wb_valid), LW'(1'b0));
        if (c == v.resp_dly) begin
          dc_resp_valid = 1'b1;
          dc_resp_rdata = v.rdata;
        end
        tick();
      end
      dc_resp_valid = 1'b0;
      dc_resp_rdata = '0;
      chk("done_wb_valid", LW'(wb_valid), LW'(1'b1));
      chk("done_stall", LW'(stall), LW'(1'b0));
      chk("done_is_load", LW'(wb_is_load), LW'(v.e_load));
      chk("done_is_vector", LW'(wb_is_vector), LW'(v.e_vec));
      chk("done_wr_reg", LW'(wb_wr_reg), LW'(v.wr));
      if (v.e_load && v.vec)  chk("done_vdata", LW'(wb_vdata), LW'(v.e_vdata));
      if (v.e_load && !v.vec) chk("done_sdata", LW'(wb_sdata), LW'(v.e_sdata));
    end
    if (idle_after) begin
      tick();
      chk("idle_wb_valid", LW'(wb_valid), LW'(1'b0));
      chk("idle_stall", LW'(stall), LW'(1'b0));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[7];
    vec_t v;
    logic [63:0]  r64;
    logic [159:0] r160;

    rst_n = 1'b0; ex_valid = 1'b0; ex_mem_op = '0; ex_vector = 1'b0; ex_addr = '0;
    ex_sdata = '0; ex_vdata = '0; ex_alu_data = '0; ex_wr_reg = '0;
    dc_req_ready = 1'b0; dc_resp_valid = 1'b0; dc_resp_rdata = '0;
    tick(); tick();
    chk("rst_stall", LW'(stall), '0);
    chk("rst_req_valid", LW'(dc_req_valid), '0);
    chk("rst_req_we", LW'(dc_req_we), '0);
    chk("rst_req_addr", LW'(dc_req_addr), '0);
    chk("rst_req_wdata", dc_req_wdata, '0);
    chk("rst_req_wmask", LW'(dc_req_wmask), '0);
    chk("rst_wb_valid", LW'(wb_valid), '0);
    chk("rst_wb_sdata", LW'(wb_sdata), '0);
    chk("rst_wb_vdata", LW'(wb_vdata), '0);
    chk("rst_wb_flags", LW'({wb_is_vector, wb_is_load, wb_wr_reg}), '0);
    chk("rst_err", LW'(err), '0);
    rst_n = 1'b1;
    tick();

    tbl[0] = mk(2'b00, 1'b0, '0, '0, '0, 36'h0_1234_5678, 5'd7, 0, 0, '0);
    tbl[0].e_sdata = 36'h0_1234_5678;
    tbl[1] = mk(2'b01, 1'b0, 36'h104, '0, '0, '0, 5'd3, 0, 0,
                {36'h3, 36'h2, 36'h1, 36'hA_BCDE_F012});
    tbl[1].e_addr = 36'h104; tbl[1].e_load = 1'b1; tbl[1].e_sdata = 36'hA_BCDE_F012;
    tbl[1].junk_resp = 1'b1;
    tbl[2] = mk(2'b10, 1'b0, 36'h203, 36'h5, '0, '0, 5'd9, 3, 1, '0);
    tbl[2].e_addr = 36'h200; tbl[2].e_we = 1'b1; tbl[2].e_wmask = 4'b1000;
    tbl[2].e_wdata = {36'h5, 36'h5, 36'h5, 36'h5};
    tbl[3] = mk(2'b01, 1'b1, 36'h40, '0, '0, '0, 5'd12, 0, 0,
                {36'hF_0000_0004, 36'h3, 36'h2, 36'h1});
    tbl[3].e_addr = 36'h40; tbl[3].e_load = 1'b1; tbl[3].e_vec = 1'b1;
    tbl[3].e_vdata = {32'h4, 32'h3, 32'h2, 32'h1};
    tbl[4] = mk(2'b11, 1'b0, 36'h55, '0, '0, 36'hF_FFFF_FFFF, 5'd31, 0, 0, '0);
    tbl[4].e_sdata = 36'hF_FFFF_FFFF;
    tbl[5] = mk(2'b10, 1'b1, 36'h1C, '0,
                {32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF, 32'hFFFF_FFFF}, '0, 5'd4, 1, 2, '0);
    tbl[5].e_addr = 36'h1C; tbl[5].e_we = 1'b1; tbl[5].e_wmask = 4'b1111;
    tbl[5].e_wdata = {36'h0_DEAD_BEEF, 36'h0_0123_4567, 36'h0_89AB_CDEF, 36'h0_FFFF_FFFF};
    tbl[6] = mk(2'b01, 1'b0, 36'h7, '0, '0, '0, 5'd20, 2, 0,
                {36'h9_8765_4321, 36'hF_FFFF_FFFF, 36'h0, 36'h0});
    tbl[6].e_addr = 36'h4; tbl[6].e_load = 1'b1; tbl[6].e_sdata = 36'h9_8765_4321;
    tbl[6].junk_resp = 1'b1;
    for (int i = 0; i < 7; i++) apply(tbl[i], 1'b1);

    // Back-to-back pass-through, then a store whose completion cycle accepts a new op.
    apply(model(mk(2'b00, 1'b0, '0, '0, '0, 36'h1_1111_1111, 5'd1, 0, 0, '0)), 1'b0);
    apply(model(mk(2'b00, 1'b0, '0, '0, '0, 36'h2_2222_2222, 5'd2, 0, 0, '0)), 1'b0);
    apply(model(mk(2'b10, 1'b0, 36'h81, 36'h7_7777_7777, '0, '0, 5'd5, 0, 0, '0)), 1'b0);
    apply(model(mk(2'b00, 1'b0, '0, '0, '0, 36'h3_3333_3333, 5'd6, 0, 0, '0)), 1'b1);

    // Reset while a request is pending.
    ex_valid = 1'b1; ex_mem_op = 2'b01; ex_vector = 1'b0; ex_addr = 36'h300;
    tick();
    ex_valid = 1'b0;
    chk("rreq_valid_before", LW'(dc_req_valid), LW'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    chk("rreq_valid_drop", LW'(dc_req_valid), '0);
    chk("rreq_stall_drop", LW'(stall), '0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rreq_after_stall", LW'(stall), '0);
    chk("rreq_after_wb", LW'(wb_valid), '0);

    // Reset while waiting for the response; the late response must be discarded.
    ex_valid = 1'b1;
    tick();
    ex_valid = 1'b0;
    dc_req_ready = 1'b1;
    tick();
    dc_req_ready = 1'b0;
    chk("rresp_stall_before", LW'(stall), LW'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    chk("rresp_stall", LW'(stall), '0);
    chk("rresp_req_valid", LW'(dc_req_valid), '0);
    chk("rresp_wb_valid", LW'(wb_valid), '0);
    tick();
    rst_n = 1'b1;
    dc_resp_valid = 1'b1;
    dc_resp_rdata = '1;
    tick();
    dc_resp_valid = 1'b0;
    chk("late_resp_wb_valid", LW'(wb_valid), '0);
    chk("late_resp_stall", LW'(stall), '0);
    tick();
    chk("late_resp_wb_valid2", LW'(wb_valid), '0);

`ifdef MEM_ALIGN_CHECK_EN
    ex_valid = 1'b1; ex_mem_op = 2'b01; ex_vector = 1'b1; ex_addr = 36'h41;
    tick();
    ex_valid = 1'b0;
    chk("mis_req_valid", LW'(dc_req_valid), '0);
    chk("mis_err", LW'(err), LW'(1'b1));
    chk("mis_wb_valid", LW'(wb_valid), '0);
    chk("mis_stall", LW'(stall), '0);
    tick();
    chk("mis_err_pulse", LW'(err), '0);
    chk("mis_req_valid2", LW'(dc_req_valid), '0);
`else
    v = mk(2'b01, 1'b1, 36'h41, '0, '0, '0, 5'd8, 0, 0, {36'h4, 36'h3, 36'h2, 36'h1});
    v = model(v);
    apply(v, 1'b0);
    chk("mis_err_tied", LW'(err), '0);
    tick();
`endif

    for (int n = 0; n < 40; n++) begin
      v = mk(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), '0, '0, '0, '0,
             5'($urandom_range(0, 31)), $urandom_range(0, 3), $urandom_range(0, 3), '0);
      r64 = {$urandom, $urandom}; v.addr = r64[AW-1:0];
`ifdef MEM_ALIGN_CHECK_EN
      if (v.vec) v.addr[1:0] = 2'b00;
`endif
      r64 = {$urandom, $urandom}; v.sdata = r64[SDATA_W-1:0];
      r64 = {$urandom, $urandom}; v.alu = r64[SDATA_W-1:0];
      v.vdata = {$urandom, $urandom, $urandom, $urandom};
      r160 = {$urandom, $urandom, $urandom, $urandom, $urandom};
      v.rdata = r160[LW-1:0];
      v.junk_resp = 1'($urandom_range(0, 1));
      apply(model(v), 1'($urandom_range(0, 1)));
      chk("rand_err", LW'(err), '0);
    end

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage between scalar execute and writeback in the scalar pipeline.
- Registers execute-stage results and issues scalar/vector loads and stores to the data cache over a valid/ready request + valid response handshake.
- Stalls upstream while an access is outstanding and delivers registered results to writeback.
- Non-memory ops pass through with 1-cycle latency.

Parameters:
- ADDR_W, 36, word address width.
- SDATA_W, 36, scalar data and cache lane width.
- LANES, 4, lanes per cache line and per vector.
- VLANE_W, 32, vector lane width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  execute result valid
- ex_mem_op  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none)
- ex_vector  in  1  access is a vector (full line) access
- ex_addr  in  ADDR_W  word address
- ex_sdata  in  SDATA_W  scalar store data
- ex_vdata  in  LANES*VLANE_W  vector store data, lane0 at LSBs
- ex_alu_data  in  SDATA_W  ALU result for pass-through
- ex_wr_reg  in  5  destination register
- stall  out  1  upstream must hold its inputs
- dc_req_valid  out  1  cache request valid
- dc_req_ready  in  1  cache accepts request
- dc_req_we  out  1  1 = store
- dc_req_addr  out  ADDR_W  line address (ex_addr with [1:0] cleared)
- dc_req_wdata  out  LANES*SDATA_W  store line
- dc_req_wmask  out  LANES  lane write enables
- dc_resp_valid  in  1  response valid; also completes stores
- dc_resp_rdata  in  LANES*SDATA_W  load line
- wb_valid  out  1  result valid to writeback
- wb_sdata  out  SDATA_W  scalar result
- wb_vdata  out  LANES*VLANE_W  vector result
- wb_is_vector  out  1  result targets the vector file
- wb_is_load  out  1  result came from memory
- wb_wr_reg  out  5  destination register
- err  out  1  misaligned vector access (feature only; otherwise tied 0)

Behaviour:
- Reset: all outputs 0, FSM in IDLE, captured-op registers 0.
- FSM states: IDLE, REQ, RESP.
- stall = (state != IDLE); combinational from state only.
- IDLE:
  - ex_valid with mem_op none/11: next cycle wb_valid=1, wb_sdata=ex_alu_data, wb_is_load=0; stay IDLE.
  - ex_valid with load/store: capture op; next state REQ; wb_valid=0 next cycle.
  - No ex_valid: wb_valid=0.
- REQ:
  - dc_req_valid=1; addr, we, wdata and wmask come from registers and stay stable until accepted.
  - Transition to RESP on dc_req_ready.
- RESP:
  - dc_req_valid=0. On dc_resp_valid, next cycle wb_valid=1 for exactly one cycle, state returns to IDLE.
  - dc_resp_valid outside RESP (including the REQ-accept cycle) is ignored.
- Scalar access:
  - Lane index is addr[1:0].
  - Store: wdata replicates ex_sdata into every lane; wmask is one-hot at the lane.
  - Load: wb_sdata = selected lane of rdata.
- Vector access:
  - Store: each lane = {4'b0, vdata lane}; wmask=4'b1111.
  - Load: wb_vdata lane i = rdata lane i [31:0]; wb_is_vector=1.
- Stores: wb_valid=1 with wb_is_load=0, so writeback sees an explicit completion; writeback must not write registers for stores.
- Throughput: minimum 3 cycles per memory op (capture, REQ accepted immediately, RESP next cycle) plus 1 cycle for writeback. Back-to-back pass-through ops run at 1 per cycle.
- The cycle on which state returns to IDLE accepts a new ex_valid op.
- Reset asserted mid-access: FSM returns to IDLE, dc_req_valid drops immediately, and the pending response is discarded.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- Defined: a vector access with ex_addr[1:0]!=0 issues no request. Next cycle wb_valid=0 and err pulses 1 for one cycle; the op is dropped and stays IDLE.
- Undefined: err tied 0 and addr[1:0] is ignored for vector accesses.

Decomposition:
- Shared package mem_pkg:
  - mem_op_t enum (MEM_NONE, MEM_LOAD, MEM_STORE).
  - mem_state_t enum (IDLE, REQ, RESP).
  - LANES, VLANE_W, SDATA_W constants.
- One sub-module, lane_pack: combinational lane replication/packing for wdata/wmask and lane extraction for loads. The FSM and registers stay in mem_access_stage.

Test Plan:
- Pass-through: ex_valid, mem_op=00, alu_data=36'h0_1234_5678, wr_reg=7 → next cycle wb_valid=1, wb_sdata=36'h012345678, wb_wr_reg=7, stall=0.
- Scalar load: addr=36'h104, rdata lane0=36'hA_BCDE_F012, ready immediate, resp one cycle after accept → dc_req_addr=36'h104, stall high 2 cycles, wb_sdata=36'hABCDEF012.
- Scalar store: addr=36'h203, sdata=36'h5 → wmask=4'b1000, we=1; dc_req_valid held 3 cycles while ready=0; wb_valid with wb_is_load=0 after resp.
- Vector load: addr=36'h40, rdata lanes {36'hF_0000_0004, 3, 2, 1} → wb_vdata={32'h4,32'h3,32'h2,32'h1}, wb_is_vector=1.
- Reset during RESP: rst_n low → dc_req_valid=0, stall=0, wb_valid=0; a late dc_resp_valid after reset produces no wb_valid.
- MEM_ALIGN_CHECK_EN: vector load at addr=36'h41 → no dc_req_valid, err=1 for one cycle, wb_valid=0.
